// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bundle for the two requester ports and the
// register-file write port that the arbiter drives.
// Ports: a_*/b_* valid/ready/addr/data requests, rf_we/rf_wm/rf_d, pending mask.
interface regfile_write_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic              a_valid;
    logic              a_ready;
    logic [AW-1:0]     a_addr;
    logic [DW-1:0]     a_data;
    logic              b_valid;
    logic              b_ready;
    logic [AW-1:0]     b_addr;
    logic [DW-1:0]     b_data;
    logic              rf_we;
    logic [AW-1:0]     rf_wm;
    logic [DW-1:0]     rf_d;
    logic [2**AW-1:0]  pending;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        input  a_ready, b_ready,
        input  rf_we, rf_wm, rf_d, pending
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        output a_ready, b_ready,
        output rf_we, rf_wm, rf_d, pending
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-port writeback arbiter: per-port FIFOs drained round-robin into a
// registered register-file write port, plus a pending-destination mask.
// Ports: clk, resetn (async active-low), bus (slave modport: a_*/b_* requests,
// rf_we/rf_wm/rf_d write port, pending mask).
// Option: define REGARB_ZERO_REG_EN to make register 0 a hard-zero sink.
module regfile_write_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input logic                   clk,
    input logic                   resetn,
    regfile_write_arbiter_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int NR = 2**AW;

`ifdef REGARB_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    ent_t mem_a [DEPTH];
    ent_t mem_b [DEPTH];

    logic [PW-1:0] wp_a, rp_a, wp_b, rp_b;
    logic [PW-1:0] cnt_a, cnt_b;
    logic          full_a, full_b;
    logic          empty_a, empty_b;
    logic          acc_a, acc_b;
    logic          pop_a, pop_b, pop;
    logic          rr_b;
    logic          drop;
    ent_t          head;
    logic          rf_we_q;
    logic [AW-1:0] rf_wm_q;
    logic [DW-1:0] rf_d_q;
    logic [NR-1:0] pend;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign full_a  = (wp_a[IW] != rp_a[IW]) &&
                     (wp_a[IW-1:0] == rp_a[IW-1:0]);
    assign full_b  = (wp_b[IW] != rp_b[IW]) &&
                     (wp_b[IW-1:0] == rp_b[IW-1:0]);
    assign empty_a = (wp_a == rp_a);
    assign empty_b = (wp_b == rp_b);
    assign cnt_a   = wp_a - rp_a;
    assign cnt_b   = wp_b - rp_b;

    assign acc_a = bus.a_valid && !full_a;
    assign acc_b = bus.b_valid && !full_b;

    // rr_b=1 means B wins the next contended cycle.
    assign pop_a = !empty_a && (empty_b || !rr_b);
    assign pop_b = !empty_b && (empty_a || rr_b);
    assign pop   = pop_a || pop_b;

    assign head = pop_a ? mem_a[rp_a[IW-1:0]] : mem_b[rp_b[IW-1:0]];
    assign drop = ZERO_REG && (head.addr == '0);

    always_ff @(posedge clk) begin
        if (acc_a) mem_a[wp_a[IW-1:0]] <= {bus.a_addr, bus.a_data};
        if (acc_b) mem_b[wp_b[IW-1:0]] <= {bus.b_addr, bus.b_data};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wp_a    <= '0;
            rp_a    <= '0;
            wp_b    <= '0;
            rp_b    <= '0;
            rr_b    <= 1'b0;
            rf_we_q <= 1'b0;
            rf_wm_q <= '0;
            rf_d_q  <= '0;
        end else begin
            if (acc_a) wp_a <= wp_a + PW'(1);
            if (acc_b) wp_b <= wp_b + PW'(1);
            if (pop_a) rp_a <= rp_a + PW'(1);
            if (pop_b) rp_b <= rp_b + PW'(1);
            if (!empty_a && !empty_b) rr_b <= !rr_b;
            rf_we_q <= pop && !drop;
            if (pop) begin
                rf_wm_q <= head.addr;
                rf_d_q  <= head.data;
            end
        end
    end

    // Walk occupied slots from the read pointer; slot count = occupancy.
    always_comb begin
        pend = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (PW'(k) < cnt_a) begin
                if (!(ZERO_REG &&
                      mem_a[rp_a[IW-1:0] + IW'(k)].addr == '0))
                    pend[mem_a[rp_a[IW-1:0] + IW'(k)].addr] = 1'b1;
            end
            if (PW'(k) < cnt_b) begin
                if (!(ZERO_REG &&
                      mem_b[rp_b[IW-1:0] + IW'(k)].addr == '0))
                    pend[mem_b[rp_b[IW-1:0] + IW'(k)].addr] = 1'b1;
            end
        end
        if (rf_we_q) pend[rf_wm_q] = 1'b1;
    end

    assign bus.a_ready = !full_a;
    assign bus.b_ready = !full_b;
    assign bus.rf_we   = rf_we_q;
    assign bus.rf_wm   = rf_wm_q;
    assign bus.rf_d    = rf_d_q;
    assign bus.pending = pend;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed vector table,
// hand-written reset/zero-register sequences, and queue-model random traffic.
module tb_regfile_write_arbiter;
    localparam int DEPTH = 2;
    localparam int AW    = 5;
    localparam int DW    = 32;

`ifdef REGARB_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        we;
        logic [4:0]  wm;
        logic [31:0] d;
        logic [31:0] pend;
        logic        ar;
        logic        br;
    } vec_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    regfile_write_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: plain queues plus a "B goes next" flag.
    ent_t        qa[$];
    ent_t        qb[$];
    bit          m_rrb;
    bit          m_we;
    logic [4:0]  m_wm;
    logic [31:0] m_d;

    bit   a_hold, b_hold;
    ent_t cur_a, cur_b;
    bit   saw_afull;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic av, input logic [4:0] aa,
                                input logic [31:0] ad, input logic bv,
                                input logic [4:0] ba, input logic [31:0] bd,
                                input logic we, input logic [4:0] wm,
                                input logic [31:0] d, input logic [31:0] pend,
                                input logic ar, input logic br);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad;
        v.bv = bv; v.ba = ba; v.bd = bd;
        v.we = we; v.wm = wm; v.d = d;
        v.pend = pend; v.ar = ar; v.br = br;
        return v;
    endfunction

    task automatic idle_inputs();
        bus.a_valid = 1'b0;
        bus.a_addr  = '0;
        bus.a_data  = '0;
        bus.b_valid = 1'b0;
        bus.b_addr  = '0;
        bus.b_data  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        a_hold = 1'b0;
        b_hold = 1'b0;
        resetn = 1'b0;
        qa.delete();
        qb.delete();
        m_rrb = 1'b0;
        m_we  = 1'b0;
        m_wm  = '0;
        m_d   = '0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    function automatic logic [31:0] model_pend();
        logic [31:0] p;
        p = '0;
        foreach (qa[i]) if (!(ZR && qa[i].addr == 0)) p[qa[i].addr] = 1'b1;
        foreach (qb[i]) if (!(ZR && qb[i].addr == 0)) p[qb[i].addr] = 1'b1;
        if (m_we) p[m_wm] = 1'b1;
        return p;
    endfunction

    // Advance the model by one clock edge using the current inputs.
    task automatic model_step();
        bit   acc_a, acc_b, use_a, use_b;
        ent_t e;
        acc_a = bus.a_valid && (qa.size() < DEPTH);
        acc_b = bus.b_valid && (qb.size() < DEPTH);
        use_a = (qa.size() > 0) && ((qb.size() == 0) || !m_rrb);
        use_b = (qb.size() > 0) && !use_a;
        if (qa.size() > 0 && qb.size() > 0) m_rrb = !m_rrb;
        m_we = 1'b0;
        if (use_a || use_b) begin
            e = use_a ? qa.pop_front() : qb.pop_front();
            m_we = !(ZR && e.addr == 0);
            m_wm = e.addr;
            m_d  = e.data;
        end
        if (acc_a) qa.push_back({bus.a_addr, bus.a_data});
        if (acc_b) qb.push_back({bus.b_addr, bus.b_data});
    endtask

    task automatic model_cmp();
        chk("m_we",   64'(bus.rf_we),   64'(m_we));
        chk("m_wm",   64'(bus.rf_wm),   64'(m_wm));
        chk("m_d",    64'(bus.rf_d),    64'(m_d));
        chk("m_pend", 64'(bus.pending), 64'(model_pend()));
        chk("m_ar",   64'(bus.a_ready), 64'(qa.size() < DEPTH));
        chk("m_br",   64'(bus.b_ready), 64'(qb.size() < DEPTH));
    endtask

    // Requests are held stable until the port accepts them.
    task automatic run(input int n, input int pa, input int pb);
        bit ar_pre, br_pre;
        for (int c = 0; c < n; c++) begin
            if (!a_hold && $urandom_range(99) < pa) begin
                a_hold = 1'b1;
                cur_a.addr = 5'($urandom_range(31));
                cur_a.data = $urandom;
            end
            if (!b_hold && $urandom_range(99) < pb) begin
                b_hold = 1'b1;
                cur_b.addr = 5'($urandom_range(31));
                cur_b.data = $urandom;
            end
            bus.a_valid = a_hold;
            bus.a_addr  = cur_a.addr;
            bus.a_data  = cur_a.data;
            bus.b_valid = b_hold;
            bus.b_addr  = cur_b.addr;
            bus.b_data  = cur_b.data;
            ar_pre = bus.a_ready;
            br_pre = bus.b_ready;
            model_step();
            @(posedge clk);
            #1;
            if (a_hold && ar_pre) a_hold = 1'b0;
            if (b_hold && br_pre) b_hold = 1'b0;
            if (!bus.a_ready) saw_afull = 1'b1;
            model_cmp();
        end
    endtask

    initial begin
        idle_inputs();
        saw_afull = 1'b0;

        tbl[0] = mk(0,0,0,          0,0,0, 0,0,0,          32'h0,  1,1);
        tbl[1] = mk(1,5,32'hDEADBEEF,0,0,0, 0,0,0,          32'h20, 1,1);
        tbl[2] = mk(0,0,0,          0,0,0, 1,5,32'hDEADBEEF,32'h20, 1,1);
        tbl[3] = mk(0,0,0,          0,0,0, 0,5,32'hDEADBEEF,32'h0,  1,1);
        tbl[4] = mk(1,1,1,          1,3,3, 0,5,32'hDEADBEEF,32'h0A, 1,1);
        tbl[5] = mk(1,2,2,          1,4,4, 1,1,1,          32'h1E, 1,0);
        tbl[6] = mk(0,0,0,          0,0,0, 1,3,3,          32'h1C, 1,1);
        tbl[7] = mk(0,0,0,          0,0,0, 1,2,2,          32'h14, 1,1);
        tbl[8] = mk(0,0,0,          0,0,0, 1,4,4,          32'h10, 1,1);
        tbl[9] = mk(0,0,0,          0,0,0, 0,4,4,          32'h0,  1,1);

        do_reset();
        chk("rst_we",   64'(bus.rf_we),   64'(0));
        chk("rst_pend", 64'(bus.pending), 64'(0));

        // Single write latency, then A/B contention order r1,r3,r2,r4.
        for (int i = 0; i < 10; i++) begin
            bus.a_valid = tbl[i].av;
            bus.a_addr  = tbl[i].aa;
            bus.a_data  = tbl[i].ad;
            bus.b_valid = tbl[i].bv;
            bus.b_addr  = tbl[i].ba;
            bus.b_data  = tbl[i].bd;
            @(posedge clk);
            #1;
            chk($sformatf("t%0d_we", i),   64'(bus.rf_we),   64'(tbl[i].we));
            chk($sformatf("t%0d_wm", i),   64'(bus.rf_wm),   64'(tbl[i].wm));
            chk($sformatf("t%0d_d", i),    64'(bus.rf_d),    64'(tbl[i].d));
            chk($sformatf("t%0d_pend", i), 64'(bus.pending), 64'(tbl[i].pend));
            chk($sformatf("t%0d_ar", i),   64'(bus.a_ready), 64'(tbl[i].ar));
            chk($sformatf("t%0d_br", i),   64'(bus.b_ready), 64'(tbl[i].br));
        end

        // Async reset with two writes queued.
        bus.a_valid = 1'b1; bus.a_addr = 5'd7; bus.a_data = 32'h77;
        bus.b_valid = 1'b1; bus.b_addr = 5'd8; bus.b_data = 32'h88;
        @(posedge clk);
        #1;
        idle_inputs();
        chk("q2_pend", 64'(bus.pending), 64'(32'h180));
        #2 resetn = 1'b0;
        #1;
        chk("arst_we",   64'(bus.rf_we),   64'(0));
        chk("arst_pend", 64'(bus.pending), 64'(0));
        chk("arst_ar",   64'(bus.a_ready), 64'(1));
        chk("arst_br",   64'(bus.b_ready), 64'(1));
        @(posedge clk);
        #1 resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("arst_nowr%0d", i), 64'(bus.rf_we), 64'(0));
        end

        // Both ports always requesting: A must fill while B holds the port.
        do_reset();
        run(12, 100, 100);
        chk("a_full_seen", 64'(saw_afull), 64'(1));
        run(6, 0, 0);

        // A alone at occupancy DEPTH-1: push and pop every cycle.
        run(10, 100, 0);
        run(4, 0, 0);

        run(400, 60, 60);
        run(8, 0, 0);
        chk("drain_pend", 64'(bus.pending), 64'(0));

        // Register-0 write.
        do_reset();
        bus.a_valid = 1'b1; bus.a_addr = 5'd0; bus.a_data = 32'h55;
        @(posedge clk);
        #1;
        idle_inputs();
`ifdef REGARB_ZERO_REG_EN
        chk("r0_pend", 64'(bus.pending[0]), 64'(0));
        @(posedge clk);
        #1;
        chk("r0_we",   64'(bus.rf_we),      64'(0));
        chk("r0_pend2",64'(bus.pending[0]), 64'(0));
`else
        chk("r0_pend", 64'(bus.pending[0]), 64'(1));
        @(posedge clk);
        #1;
        chk("r0_we",   64'(bus.rf_we),      64'(1));
        chk("r0_wm",   64'(bus.rf_wm),      64'(0));
        chk("r0_d",    64'(bus.rf_d),       64'(32'h55));
`endif
        @(posedge clk);
        #1;
        chk("r0_after", 64'(bus.rf_we), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
